// File: rtl/cdb_arbiter_pkg.sv
// Shared tag encoding for the CDB arbiter and queues.
// Label 0 means "no pending producer".
package cdb_arbiter_pkg;

  localparam int LABEL_W = 5;
  localparam logic [LABEL_W-1:0] NO_LABEL = '0;

endpackage

`ifndef CDB_TAGS_DEFINED
`define CDB_TAGS_DEFINED
`define Q0 5'd0
`define Q1 5'd1
`define Q2 5'd2
`define Q3 5'd3
`define Q4 5'd4
`define Q5 5'd5
`define Q6 5'd6
`define Q7 5'd7
`endif

// File: rtl/cdb_arbiter_rr.sv
// Round-robin grant generator: rotate requests by rrPtr,
// isolate the lowest set bit, rotate the one-hot grant back.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         RST,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]  rrPtr;
    logic [PW-1:0]  nextPtr;
    logic [2*N-1:0] reqDbl;
    logic [2*N-1:0] priDbl;
    logic [N-1:0]   rot;
    logic [N-1:0]   pri;

    always_comb begin
        reqDbl = {req, req} >> rrPtr;
        rot    = reqDbl[N-1:0];
        pri    = rot & (~rot + N'(1));
        priDbl = {pri, pri} << rrPtr;
        grant  = priDbl[2*N-1:N];
    end

    always_comb begin
        nextPtr = rrPtr;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                nextPtr = (i == N - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            rrPtr <= '0;
        end else if (advance) begin
            rrPtr <= nextPtr;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one registered broadcast per cycle, round-robin.
// Define CDB_STATS_EN to add the bc_count / conflict_count statistics outputs.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int LABEL_W = cdb_arbiter_pkg::LABEL_W
) (
    input  logic                       clk,
    input  logic                       RST,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*LABEL_W-1:0] req_label,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       BCEN,
    output logic [LABEL_W-1:0]         BClabel,
    output logic [DATA_W-1:0]          BCdata
`ifdef CDB_STATS_EN
    ,
    output logic [31:0]                bc_count,
    output logic [31:0]                conflict_count
`endif
);

    logic               transfer;
    logic [LABEL_W-1:0] selLabel;
    logic [DATA_W-1:0]  selData;

    rr_arbiter #(.N(NUM_REQ)) uArb (
        .clk    (clk),
        .RST    (RST),
        .req    (req_valid),
        .advance(transfer),
        .grant  (req_ready)
    );

    always_comb begin
        transfer = |(req_valid & req_ready);
        selLabel = '0;
        selData  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                selLabel = selLabel | req_label[i*LABEL_W +: LABEL_W];
                selData  = selData  | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // A zero tag still takes its slot but must never wake a consumer.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            BCEN    <= 1'b0;
            BClabel <= '0;
            BCdata  <= '0;
        end else if (transfer && selLabel != LABEL_W'(NO_LABEL)) begin
            BCEN    <= 1'b1;
            BClabel <= selLabel;
            BCdata  <= selData;
        end else begin
            BCEN    <= 1'b0;
            BClabel <= '0;
            BCdata  <= '0;
        end
    end

`ifdef CDB_STATS_EN
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            bc_count       <= '0;
            conflict_count <= '0;
        end else begin
            if (BCEN) begin
                bc_count <= bc_count + 32'd1;
            end
            if ($countones(req_valid) >= 2) begin
                conflict_count <= conflict_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with a cycle-tagged broadcast scoreboard.
// Define CDB_STATS_EN to also check the statistics counters.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        RST;
    logic [3:0]  reqValid;
    logic [19:0] reqLabel;
    logic [127:0] reqData;
    logic [3:0]  reqReady;
    logic        BCEN;
    logic [4:0]  BClabel;
    logic [31:0] BCdata;
`ifdef CDB_STATS_EN
    logic [31:0] bcCount;
    logic [31:0] conflictCount;
`endif

    logic [4:0]  lbl [4];
    logic [31:0] dat [4];

    typedef struct {
        int          cyc;
        logic        en;
        logic [4:0]  label;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   nChecks = 0;
    int   nFails = 0;

    cdb_arbiter dut (
        .clk           (clk),
        .RST           (RST),
        .req_valid     (reqValid),
        .req_label     (reqLabel),
        .req_data      (reqData),
        .req_ready     (reqReady),
        .BCEN          (BCEN),
        .BClabel       (BClabel),
        .BCdata        (BCdata)
`ifdef CDB_STATS_EN
        ,
        .bc_count      (bcCount),
        .conflict_count(conflictCount)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            reqLabel[i*5 +: 5]   = lbl[i];
            reqData[i*32 +: 32]  = dat[i];
        end
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: compares the broadcast triple against the entry due this cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk("BCEN", 32'(BCEN), 32'(e.en));
            chk("BClabel", 32'(BClabel), 32'(e.label));
            chk("BCdata", BCdata, e.data);
        end else if (BCEN !== 1'b0) begin
            chk("unexpected BCEN", 32'(BCEN), 32'd0);
        end
    end

    task automatic setReq(input int i, input logic [4:0] l, input logic [31:0] d);
        lbl[i] = l;
        dat[i] = d;
    endtask

    task automatic step(input logic [3:0] v, input logic [3:0] expReady,
                        input logic expEn, input logic [4:0] expLbl,
                        input logic [31:0] expDat);
        reqValid = v;
        #1;
        chk("req_ready", 32'(reqReady), 32'(expReady));
        sb.push_back('{cyc + 1, expEn, expLbl, expDat});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        reqValid = '0;
        for (int i = 0; i < 4; i++) setReq(i, 5'd0, 32'd0);
        #2;
        chk("reset BCEN", 32'(BCEN), 32'd0);
        chk("reset BClabel", 32'(BClabel), 32'd0);
        chk("reset BCdata", BCdata, 32'd0);
        chk("reset req_ready", 32'(reqReady), 32'd0);
        @(negedge clk);
        RST = 1'b0;
        @(posedge clk);
        #1;

        // Round-robin from pointer 0, each producer leaves after its grant
        for (int i = 0; i < 4; i++) setReq(i, 5'(i + 1), 32'h100 + 32'(i));
        step(4'b1111, 4'b0001, 1'b1, 5'd1, 32'h100);
        step(4'b1110, 4'b0010, 1'b1, 5'd2, 32'h101);
        step(4'b1100, 4'b0100, 1'b1, 5'd3, 32'h102);
        step(4'b1000, 4'b1000, 1'b1, 5'd4, 32'h103);
        step(4'b0000, 4'b0000, 1'b0, 5'd0, 32'h0);

        // Single producer
        setReq(2, 5'd7, 32'hDEADBEEF);
        step(4'b0100, 4'b0100, 1'b1, 5'd7, 32'hDEADBEEF);
        step(4'b0000, 4'b0000, 1'b0, 5'd0, 32'h0);

        // Two persistent producers alternate (pointer starts at 3)
        setReq(0, 5'd10, 32'hA0);
        setReq(2, 5'd12, 32'hC0);
        step(4'b0101, 4'b0001, 1'b1, 5'd10, 32'hA0);
        setReq(0, 5'd10, 32'hA1);
        step(4'b0101, 4'b0100, 1'b1, 5'd12, 32'hC0);
        setReq(2, 5'd12, 32'hC1);
        step(4'b0101, 4'b0001, 1'b1, 5'd10, 32'hA1);
        step(4'b0101, 4'b0100, 1'b1, 5'd12, 32'hC1);
        step(4'b0000, 4'b0000, 1'b0, 5'd0, 32'h0);

        // Label 0 is granted silently and moves the pointer to 2
        setReq(1, 5'd0, 32'h1);
        step(4'b0010, 4'b0010, 1'b0, 5'd0, 32'h0);
        setReq(3, 5'd9, 32'h99);
        step(4'b1010, 4'b1000, 1'b1, 5'd9, 32'h99);
        step(4'b0000, 4'b0000, 1'b0, 5'd0, 32'h0);

        // Reset while a broadcast is on the bus
        setReq(0, 5'd5, 32'h55);
        step(4'b0001, 4'b0001, 1'b1, 5'd5, 32'h55);
        reqValid = '0;
        @(negedge clk);
        #2;
        RST = 1'b1;
        #1;
        chk("async BCEN", 32'(BCEN), 32'd0);
        chk("async BClabel", 32'(BClabel), 32'd0);
        chk("async BCdata", BCdata, 32'd0);
`ifdef CDB_STATS_EN
        chk("reset bc_count", bcCount, 32'd0);
        chk("reset conflict_count", conflictCount, 32'd0);
`endif
        @(negedge clk);
        RST = 1'b0;
        @(posedge clk);
        #1;

        // Pointer back at 0 after reset; 5 grants, 3 conflict cycles
        setReq(0, 5'd21, 32'h210);
        setReq(1, 5'd22, 32'h220);
        setReq(3, 5'd23, 32'h230);
        setReq(2, 5'd24, 32'h240);
        step(4'b1011, 4'b0001, 1'b1, 5'd21, 32'h210);
        step(4'b1010, 4'b0010, 1'b1, 5'd22, 32'h220);
        step(4'b1000, 4'b1000, 1'b1, 5'd23, 32'h230);
        step(4'b0101, 4'b0001, 1'b1, 5'd21, 32'h210);
        step(4'b0100, 4'b0100, 1'b1, 5'd24, 32'h240);
        step(4'b0000, 4'b0000, 1'b0, 5'd0, 32'h0);
        step(4'b0000, 4'b0000, 1'b0, 5'd0, 32'h0);
`ifdef CDB_STATS_EN
        chk("bc_count", bcCount, 32'd5);
        chk("conflict_count", conflictCount, 32'd3);
`endif

        @(negedge clk);
        #1;
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Common Data Bus arbiter for the Tomasulo core.
- Collects completed results (tag label + 32-bit value) from NUM_REQ functional units and grants one per cycle, round-robin.
- Drives the registered broadcast triple BCEN/BClabel/BCdata that every reservation-station queue and the register status table snoop.

Parameters:
- NUM_REQ, 4, number of result producers (ALU, MUL, LOAD, ...); legal range 2..8.
- DATA_W, 32, result value width.
- LABEL_W, 5, tag width; label 0 is reserved for "no pending producer".

Ports:
- clk  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-producer result valid.
- req_label  in  NUM_REQ*LABEL_W  per-producer tag; slice i = bits [i*LABEL_W +: LABEL_W].
- req_data  in  NUM_REQ*DATA_W  per-producer value; slice i = bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] && req_ready[i].
- BCEN  out  1  broadcast valid.
- BClabel  out  LABEL_W  broadcast tag.
- BCdata  out  DATA_W  broadcast value.

Behaviour:
- Reset: BCEN=0, BClabel=0, BCdata=0, rr_ptr=0. req_ready is combinational, so it is all-zero whenever req_valid=0.
- Handshake:
  - A producer raises req_valid and holds label/data stable until it sees req_ready high on a clock edge.
  - A producer must not drop valid before it is granted.
  - req_ready[i] is combinational from req_valid and rr_ptr; it never depends on BCEN.
- Arbitration:
  - Scan indices rr_ptr, rr_ptr+1, ... mod NUM_REQ; the first with valid=1 is granted.
  - At most one req_ready bit is high per cycle.
- Pointer update: on a transfer from index g, rr_ptr <= (g+1) mod NUM_REQ. With no transfer, rr_ptr holds.
- Latency:
  - A transfer at edge t produces BCEN=1, BClabel=req_label[g], BCdata=req_data[g] during cycle t+1, for exactly one cycle.
  - With no transfer at edge t, BCEN=0 in cycle t+1.
  - BClabel/BCdata are cleared to 0 when BCEN=0.
- Throughput: one broadcast per cycle. Back-to-back grants to the same producer are allowed only when no other producer is valid.
- Fairness: a continuously valid producer waits at most NUM_REQ-1 cycles.
- Label 0 on a valid request:
  - The request is still granted (consumes its slot, advances rr_ptr).
  - BCEN stays 0 for that cycle, since a zero tag must never wake a consumer.
- Reset mid-operation: a pending broadcast is discarded and rr_ptr returns to 0. Producers re-present after reset.
- No internal buffering beyond the single output register; the block holds no state besides rr_ptr and the broadcast register.

Optional Feature:
- CDB_STATS_EN defined:
  - Adds outputs bc_count[31:0] and conflict_count[31:0], both reset to 0 by RST and wrapping at 2^32.
  - bc_count increments on each cycle with BCEN=1.
  - conflict_count increments on each cycle where two or more req_valid bits are high.
- Undefined: the ports and counters do not exist, and the broadcast behaviour is identical.

Decomposition:
- Shared package/header holds:
  - LABEL_W;
  - the reserved NO_LABEL=0 constant;
  - the reservation-station tag constants (`q0, `q1, `q2 and peers), so the arbiter and the queues agree on tag encoding.
- One natural sub-module, rr_arbiter (parameter N):
  - inputs req[N], advance, clk, RST;
  - outputs one-hot grant[N];
  - contains rr_ptr and the rotate/priority-encode/rotate-back logic.
- cdb_arbiter instantiates it and adds the data mux and the broadcast register.

Test Plan:
- Reset: assert RST mid-stream while BCEN=1 → BCEN=0, BClabel=0, BCdata=0 immediately (asynchronous); first grant after release goes to index 0.
- Single producer: req_valid=4'b0100, label=5'd7, data=32'hDEADBEEF → req_ready=4'b0100 the same cycle; next cycle BCEN=1, BClabel=7, BCdata=DEADBEEF; following cycle BCEN=0.
- Round-robin: all four valid for 4 cycles, each producer dropping valid after its grant → grants in order 0,1,2,3 on consecutive cycles; 4 consecutive BCEN pulses carrying each producer's label.
- Fairness under pressure: producers 0 and 2 permanently valid (re-presenting new data after each grant) → grants alternate 0,2,0,2; no gap cycles.
- Label 0: producer 1 valid with label 0, data 32'h1 → req_ready[1]=1; next cycle BCEN=0; rr_ptr advances to 2.
- CDB_STATS_EN: 3 cycles with 2+ valid and 5 total grants with nonzero labels → conflict_count=3, bc_count=5; both read 0 after RST.
